uart_tx_fifo: RTL and testbench

Parametrised successor to the single-word UART transmitter. Adds a transmit FIFO, configurable frame format (data bits, stop bits, optional parity) and an exact integer baud divider. It sits between the host-side write port and the serial `tx` pin and emits back-to-back standard UART frames (LSB first) with no idle gap while data is queued.

---
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: configurable data/stop bits, integer baud divider.
// Optional parity bit is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_BITS-1:0]             wr_data,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic                             parity_en,
    input  logic                             parity_odd,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int BAUD_DIV = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 push, pop, empty, tick;

    assign empty      = (level == '0);
    assign wr_ready   = (level != LW'(FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign tick       = (cnt == CW'(BAUD_DIV - 1));
    assign busy       = (state_q != IDLE) || !empty;
    assign fifo_level = level;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_bit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (pop) begin
            par_en_q  <= parity_en;
            par_bit_q <= (^mem[rd_ptr]) ^ parity_odd;
        end
    end
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: if (tick) state_d = DATA;
            DATA: begin
                if (tick && bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? PARITY : STOP;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_d = STOP;
`endif
            STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (tick && stop_idx == 1'(STOP_BITS - 1)) begin
                    if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        unique case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = par_bit_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
        end else begin
            if (state_q == IDLE || tick) cnt <= '0;
            else                         cnt <= cnt + CW'(1);

            if (state_q != DATA)  bit_idx <= '0;
            else if (tick)        bit_idx <= bit_idx + BW'(1);

            if (state_q != STOP)  stop_idx <= 1'b0;
            else if (tick)        stop_idx <= ~stop_idx;

            if (pop)                          shift <= mem[rd_ptr];
            else if (state_q == DATA && tick) shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: 8N1 and 8N2 instances at BAUD_DIV = 10.
// A line monitor decodes frames and compares each bit against queued words.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       odd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] wr_data = '0;
    logic       wr_valid = 1'b0;
    logic       wr_valid2 = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       wr_ready, tx, busy;
    logic       wr_ready2, tx2, busy2;
    logic [2:0] fifo_level, fifo_level2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frames = 0;
    int last_start = -1;
    bit gap_on = 1'b0;

    exp_t sb[$];

    uart_tx_fifo #(
        .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4),
        .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx), .busy(busy), .fifo_level(fifo_level)
    );

    uart_tx_fifo #(
        .DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4),
        .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_valid(wr_valid2),
        .wr_ready(wr_ready2), .parity_en(parity_en), .parity_odd(parity_odd),
        .tx(tx2), .busy(busy2), .fifo_level(fifo_level2)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_bit(input exp_t e, input int k);
        if (k == 0) return 0;
        if (k <= 8) return int'(e.d[k-1]);
        if (k == 9 && e.p) return int'((^e.d) ^ e.odd);
        return 1;
    endfunction

    // Line monitor: start detected on a low sample, bits checked mid-period.
    bit   mon_act = 1'b0;
    int   mon_pos = 0;
    int   mon_len = 100;
    exp_t cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act = 1'b1;
                mon_pos = 0;
                frames++;
                if (sb.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    cur = '{d: 8'h00, p: 1'b0, odd: 1'b0};
                end else begin
                    cur = sb.pop_front();
                end
                mon_len = cur.p ? 110 : 100;
                if (gap_on && last_start >= 0)
                    chk("start_gap", cyc - last_start, 100);
                last_start = cyc;
            end
        end else begin
            mon_pos++;
            if (mon_pos % 10 == 5)
                chk($sformatf("bit%0d_d%02h", mon_pos / 10, cur.d),
                    int'(tx), exp_bit(cur, mon_pos / 10));
            if (mon_pos == mon_len - 1) mon_act = 1'b0;
        end
    end

    task automatic push1(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        sb.push_back('{d: d, p: PAR_ON && parity_en, odd: parity_odd});
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run2(input logic lvl, output int n);
        n = 0;
        while (tx2 == lvl && busy2 && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk(tag, int'(busy), 0);
    endtask

    initial begin
        int n;
        int f0;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(wr_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_tx2", int'(tx2), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single 8N1 frame and pop latency
        push1(8'h55);
        chk("lat_busy", int'(busy), 1);
        chk("lat_level", int'(fifo_level), 1);
        chk("lat_tx_idle", int'(tx), 1);
        @(negedge clk);
        chk("lat_tx_fall", int'(tx), 0);
        chk("pop_level", int'(fifo_level), 0);
        busy_len(n);
        chk("busy_len_55", n, 100);
        chk("sb_single", sb.size(), 0);
        repeat (5) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push1(8'h07);
        @(negedge clk);
        parity_odd = 1'b1;
        busy_len(n);
        chk("par_even_len", n, 110);
        repeat (3) @(negedge clk);
        push1(8'h07);
        @(negedge clk);
        parity_odd = 1'b0;
        busy_len(n);
        chk("par_odd_len", n, 110);
        parity_en = 1'b0;
`else
        parity_en  = 1'b1;
        parity_odd = 1'b1;
        push1(8'h07);
        @(negedge clk);
        busy_len(n);
        chk("nopar_len", n, 100);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
`endif
        chk("sb_parity", sb.size(), 0);
        repeat (5) @(negedge clk);

        // Fill: six pushes, five accepted, frames back-to-back
        gap_on     = 1'b1;
        last_start = -1;
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            wr_data  = d;
            wr_valid = 1'b1;
            chk($sformatf("fill_ready%0d", i), int'(wr_ready), (i < 5) ? 1 : 0);
            if (i < 5) sb.push_back('{d: d, p: 1'b0, odd: 1'b0});
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("fill_level", int'(fifo_level), 4);
        chk("fill_full_ready", int'(wr_ready), 0);
        wait_idle("fill_timeout");
        chk("fill_frames", frames - f0, 5);
        chk("sb_fill", sb.size(), 0);
        gap_on = 1'b0;

        // Two stop bits on the second instance
        wr_data   = 8'h00;
        wr_valid2 = 1'b1;
        repeat (2) @(negedge clk);
        wr_valid2 = 1'b0;
        run2(1'b0, n);
        chk("s2_low0", n, 90);
        run2(1'b1, n);
        chk("s2_high0", n, 20);
        run2(1'b0, n);
        chk("s2_low1", n, 90);
        run2(1'b1, n);
        chk("s2_high1", n, 20);
        chk("s2_busy", int'(busy2), 0);

        // Reset during data bit 3 with two words queued
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'hA0 + 8'(i);
            sb.push_back('{d: wr_data, p: 1'b0, odd: 1'b0});
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("mid_level", int'(fifo_level), 2);
        repeat (44) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", int'(tx), 1);
        chk("mid_rst_level", int'(fifo_level), 0);
        chk("mid_rst_ready", int'(wr_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        f0 = frames;
        repeat (300) @(negedge clk);
        chk("post_rst_frames", frames - f0, 0);
        chk("post_rst_tx", int'(tx), 1);
        chk("post_rst_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
